// File: rtl/vend_pkg.sv
// Shared definitions for the vending credit/actuator controller.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VEND    = 3'd2,
    CHANGE  = 3'd3,
    FAULT   = 3'd4
  } vend_state_t;

  localparam int COIN5_VAL  = 5;
  localparam int COIN10_VAL = 10;

endpackage

// File: rtl/vend_ack_timer.sv
// Watchdog for actuator handshakes: counts cycles while enabled and flags
// the cycle on which the next edge would reach ACK_TIMEOUT.
module vend_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] count_r;

  // Cycle counter, held at the threshold once expired.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !expired) begin
      count_r <= count_r + TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == TW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/vend_controller.sv
// Coin credit accumulation and one-at-a-time sequencing of the dispense
// motor and change hopper, with cancel refund and sticky timeout fault.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE       = 15,
  parameter int CREDIT_W    = 6,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                cancel,
  input  logic                vend_ack,
  input  logic                eject_ack,
  output logic                vend_req,
  output logic                eject_req,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                fault
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] C5_C    = CREDIT_W'(COIN5_VAL);
  localparam logic [CREDIT_W-1:0] C10_C   = CREDIT_W'(COIN10_VAL);

  vend_state_t         state_r, state_nxt_s;
  logic [CREDIT_W-1:0] credit_r, credit_nxt_s;
  logic                reject_s, ack_s;
  logic                timer_clear_s, timer_en_s, timer_expired_s;
  logic                vend_req_r, eject_req_r, busy_r, coin_reject_r, fault_r;

  // Next state, credit arithmetic and coin rejection.
  always_comb begin
    state_nxt_s  = state_r;
    credit_nxt_s = credit_r;
    reject_s     = 1'b0;
    ack_s        = 1'b0;
    case (state_r)
      IDLE, COLLECT: begin
        if (cancel && (state_r == COLLECT)) begin
          state_nxt_s = CHANGE;
          reject_s    = coin_5 | coin_10;
        end else begin
          // coin_10 wins a simultaneous insert; the ₹5 coin goes back
          if (coin_10) begin
            credit_nxt_s = credit_r + C10_C;
            reject_s     = coin_5;
          end else if (coin_5) begin
            credit_nxt_s = credit_r + C5_C;
          end else begin
            credit_nxt_s = credit_r;
          end
          if (credit_nxt_s >= PRICE_C) begin
            state_nxt_s = VEND;
          end else if (credit_nxt_s != '0) begin
            state_nxt_s = COLLECT;
          end else begin
            state_nxt_s = IDLE;
          end
        end
      end
      VEND: begin
        reject_s = coin_5 | coin_10;
        if (vend_ack) begin
          ack_s        = 1'b1;
          credit_nxt_s = credit_r - PRICE_C;
          state_nxt_s  = (credit_nxt_s != '0) ? CHANGE : IDLE;
        end else if (timer_expired_s) begin
          state_nxt_s = FAULT;
        end else begin
          state_nxt_s = VEND;
        end
      end
      CHANGE: begin
        reject_s = coin_5 | coin_10;
        if (eject_ack) begin
          ack_s        = 1'b1;
          credit_nxt_s = credit_r - C5_C;
          state_nxt_s  = (credit_nxt_s != '0) ? CHANGE : IDLE;
        end else if (timer_expired_s) begin
          state_nxt_s = FAULT;
        end else begin
          state_nxt_s = CHANGE;
        end
      end
      FAULT: begin
        reject_s = coin_5 | coin_10;
      end
      default: begin
        state_nxt_s  = IDLE;
        credit_nxt_s = '0;
      end
    endcase
  end

  assign timer_en_s    = (state_r == VEND) || (state_r == CHANGE);
  assign timer_clear_s = ack_s || (state_nxt_s != state_r);

  vend_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .expired (timer_expired_s)
  );

  // State, credit and outputs; outputs are decoded from the next state so
  // requests and credit change on the same edge as the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      credit_r      <= '0;
      vend_req_r    <= 1'b0;
      eject_req_r   <= 1'b0;
      busy_r        <= 1'b0;
      coin_reject_r <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      credit_r      <= credit_nxt_s;
      vend_req_r    <= (state_nxt_s == VEND);
      eject_req_r   <= (state_nxt_s == CHANGE);
      busy_r        <= (state_nxt_s == VEND) || (state_nxt_s == CHANGE) ||
                       (state_nxt_s == FAULT);
      coin_reject_r <= reject_s;
      fault_r       <= (state_nxt_s == FAULT);
    end
  end

  assign vend_req    = vend_req_r;
  assign eject_req   = eject_req_r;
  assign credit      = credit_r;
  assign busy        = busy_r;
  assign coin_reject = coin_reject_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench: directed scenarios plus random traffic compared
// every cycle against a behavioural model of credit and actuator rules.
module tb_vend_controller;

  localparam int PRICE       = 15;
  localparam int CREDIT_W    = 6;
  localparam int ACK_TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                coin_5 = 1'b0, coin_10 = 1'b0, cancel = 1'b0;
  logic                vend_ack = 1'b0, eject_ack = 1'b0;
  logic                vend_req, eject_req, busy, coin_reject, fault;
  logic [CREDIT_W-1:0] credit;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: credit in rupees, which actuator is waiting, cycles waited
  int m_credit = 0;
  bit m_vend = 0, m_change = 0, m_fault = 0, m_rej = 0;
  int m_wait = 0;

  always #5 clk = ~clk;

  vend_controller #(
    .PRICE(PRICE), .CREDIT_W(CREDIT_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .coin_5(coin_5), .coin_10(coin_10), .cancel(cancel),
    .vend_ack(vend_ack), .eject_ack(eject_ack), .vend_req(vend_req),
    .eject_req(eject_req), .credit(credit), .busy(busy),
    .coin_reject(coin_reject), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit c5, c10, cn, va, ea, r);
    m_rej = 1'b0;
    if (r) begin
      m_credit = 0; m_vend = 0; m_change = 0; m_fault = 0; m_wait = 0;
    end else if (m_fault) begin
      m_rej = c5 | c10;
    end else if (m_vend || m_change) begin
      m_rej = c5 | c10;
      if (m_vend && va) begin
        m_credit -= PRICE;
        m_vend   = 0;
        m_change = (m_credit > 0);
        m_wait   = 0;
      end else if (m_change && ea) begin
        m_credit -= 5;
        m_change = (m_credit > 0);
        m_wait   = 0;
      end else begin
        m_wait++;
        if (m_wait == ACK_TIMEOUT) begin
          m_fault = 1; m_vend = 0; m_change = 0;
        end
      end
    end else if (cn && m_credit > 0) begin
      m_rej    = c5 | c10;
      m_change = 1;
      m_wait   = 0;
    end else begin
      m_rej = c5 && c10;
      m_credit += c10 ? 10 : (c5 ? 5 : 0);
      if (m_credit >= PRICE) begin
        m_vend = 1;
        m_wait = 0;
      end
    end
  endtask

  task automatic step(input bit c5, c10, cn, va, ea, r);
    @(negedge clk);
    coin_5 = c5; coin_10 = c10; cancel = cn;
    vend_ack = va; eject_ack = ea; rst = r;
    @(posedge clk);
    model_edge(c5, c10, cn, va, ea, r);
    #1;
    check("vend_req", vend_req, m_vend);
    check("eject_req", eject_req, m_change);
    check("credit", credit, m_credit);
    check("busy", busy, m_vend | m_change | m_fault);
    check("fault", fault, m_fault);
    check("coin_reject", coin_reject, m_rej);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("reset_credit", credit, 0);
    check("reset_busy", busy, 0);

    // Exact payment, no change
    step(1, 0, 0, 0, 0, 0);
    check("tp1_credit5", credit, 5);
    step(0, 1, 0, 0, 0, 0);
    check("tp1_credit15", credit, 15);
    check("tp1_vend_req", vend_req, 1);
    idle(3);
    step(0, 0, 0, 1, 0, 0);
    check("tp1_credit0", credit, 0);
    check("tp1_no_eject", eject_req, 0);
    idle(2);

    // Overpay, one ₹5 change without idle gap
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("tp2_credit20", credit, 20);
    step(0, 0, 0, 1, 0, 0);
    check("tp2_credit5", credit, 5);
    check("tp2_eject_req", eject_req, 1);
    step(0, 0, 0, 0, 1, 0);
    check("tp2_credit0", credit, 0);
    check("tp2_eject_drop", eject_req, 0);

    // Cancel with a coin in the same cycle, refund 10 as two coins
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    check("tp3_reject", coin_reject, 1);
    check("tp3_credit10", credit, 10);
    step(0, 0, 0, 0, 1, 0);
    check("tp3_credit5", credit, 5);
    step(0, 0, 0, 0, 1, 0);
    check("tp3_credit0", credit, 0);
    idle(1);

    // Simultaneous coins, then a coin during VEND
    step(1, 1, 0, 0, 0, 0);
    check("tp4_credit10", credit, 10);
    check("tp4_reject", coin_reject, 1);
    step(0, 0, 0, 0, 0, 0);
    check("tp4_reject_pulse", coin_reject, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("tp4_vend_reject", coin_reject, 1);
    check("tp4_vend_credit", credit, 15);
    step(0, 0, 0, 1, 0, 0);
    idle(1);

    // Timeout to FAULT
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(ACK_TIMEOUT - 1);
    check("tp5_pre_fault", fault, 0);
    idle(1);
    check("tp5_fault", fault, 1);
    check("tp5_vend_drop", vend_req, 0);
    check("tp5_credit", credit, 15);
    step(0, 1, 0, 1, 0, 0);
    check("tp5_reject", coin_reject, 1);
    step(0, 0, 0, 0, 0, 1);
    check("tp5_rst_fault", fault, 0);
    check("tp5_rst_credit", credit, 0);

    // Reset mid-CHANGE, then a stray ack in IDLE
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("tp6_in_change", eject_req, 1);
    step(0, 0, 0, 0, 0, 1);
    check("tp6_eject_drop", eject_req, 0);
    check("tp6_credit0", credit, 0);
    step(0, 0, 0, 1, 1, 0);
    check("tp6_stray_ack", busy, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
